// File: rtl/arbitro_mem_dados.sv
// rtl/arbitro_mem_dados.sv - DataMEM arbiter between the nRisc core and a burst loader
module arbitro_mem_dados #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_ler,
    input  logic              cpu_escrev,
    input  logic [ADDR_W-1:0] cpu_end,
    input  logic [DATA_W-1:0] cpu_dado,
    output logic [DATA_W-1:0] cpu_saida,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_end,
    input  logic [LEN_W-1:0]  ldr_len,
    input  logic [DATA_W-1:0] ldr_dado,
    output logic [DATA_W-1:0] ldr_saida,
    output logic              ldr_beat,
    output logic              ldr_done,
    output logic              mem_leitura,
    output logic              mem_escrita,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_entrada,
    input  logic [DATA_W-1:0] mem_saida
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {LIVRE, RAJADA, FIM} estado_t;

    estado_t           estado;
    logic [WW-1:0]     wait_cnt;
    logic [LEN_W-1:0]  len_cnt;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;

    logic cpu_acc;
    logic forcado;
    logic concede;

    // Grant decision: loader wins when the CPU is idle or it has waited MAX_WAIT refusals
    always_comb begin
        cpu_acc = cpu_ler | cpu_escrev;
        forcado = (estado == LIVRE) && ldr_req && (wait_cnt == WW'(MAX_WAIT));
        concede = (estado == LIVRE) && ldr_req && (!cpu_acc || forcado);
    end

    // Ownership FSM, burst address/length counters and loader starvation counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= LIVRE;
            wait_cnt <= '0;
            len_cnt  <= '0;
            addr_reg <= '0;
            we_reg   <= 1'b0;
        end else begin
            case (estado)
                LIVRE: begin
                    if (concede) begin
                        wait_cnt <= '0;
                        addr_reg <= ldr_end;
                        len_cnt  <= ldr_len;
                        we_reg   <= ldr_we;
                        estado   <= (ldr_len == '0) ? FIM : RAJADA;
                    end else if (!ldr_req) begin
                        wait_cnt <= '0;
                    end else if (cpu_acc) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RAJADA: begin
                    addr_reg <= addr_reg + 1'b1;
                    len_cnt  <= len_cnt - 1'b1;
                    if (len_cnt == LEN_W'(1)) begin
                        estado <= FIM;
                    end
                end
                FIM: begin
                    estado <= LIVRE;
                end
                default: begin
                    estado <= LIVRE;
                end
            endcase
        end
    end

    // Memory port steering; everything is held low while Reset is asserted
    always_comb begin
        cpu_saida    = '0;
        cpu_stall    = 1'b0;
        ldr_saida    = '0;
        ldr_beat     = 1'b0;
        ldr_done     = 1'b0;
        mem_leitura  = 1'b0;
        mem_escrita  = 1'b0;
        mem_endereco = '0;
        mem_entrada  = '0;
        if (!Reset) begin
            if (estado == RAJADA) begin
                cpu_stall    = 1'b1;
                ldr_beat     = 1'b1;
                mem_endereco = addr_reg;
                mem_escrita  = we_reg;
                mem_leitura  = !we_reg;
                mem_entrada  = ldr_dado;
                ldr_saida    = mem_saida;
            end else begin
                // LIVRE and FIM: CPU passes through unless a forced grant blocks it
                cpu_stall    = forcado;
                ldr_done     = (estado == FIM);
                mem_endereco = cpu_end;
                mem_entrada  = cpu_dado;
                mem_leitura  = cpu_ler & !forcado;
                mem_escrita  = cpu_escrev & !forcado;
                cpu_saida    = mem_saida;
            end
        end
    end

endmodule
